// File: rtl/skidbuf_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin arbiter
// and its output skid buffer.
package skidbuf_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Source-id width; a two-requester arbiter still needs one bit.
    function automatic int id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/skidbuf.sv
// Generic two-entry valid/ready skid buffer: an output register plus one skid
// register, with in_ready driven only from state so out_ready never reaches it.
module skidbuf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_reg;
    logic             skid_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             in_fire;
    logic             out_free;

    // Held low through reset so no upstream beat is accepted while it is asserted.
    assign in_ready  = reset_n & ~skid_valid_reg;
    assign in_fire   = in_valid & in_ready;
    assign out_free  = ~out_valid_reg | out_ready;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_data_reg   <= '0;
            skid_data_reg  <= '0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= skid_data_reg;
                skid_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= in_fire;
                if (in_fire) begin
                    out_data_reg <= in_data;
                end
            end
        end else if (in_fire) begin
            // Output is stalled: park the beat; in_ready drops next cycle.
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
        end
    end

endmodule

// File: rtl/skidbuf_rr_arb.sv
// Packet-aware round-robin arbiter sharing one skid-buffered output stream
// among NUM_REQ requesters; a winner keeps the output until its last beat.
module skidbuf_rr_arb
    import skidbuf_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_REQ-1:0]                  in_valid,
    output logic [NUM_REQ-1:0]                  in_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_REQ-1:0]                  in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_last,
    output logic [ID_WIDTH-1:0]                 out_id
);

    localparam int                PAYLOAD_W = ID_WIDTH + 1 + DATA_WIDTH;
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

    arb_state_t              state_reg, state_next;
    logic [ID_WIDTH-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [ID_WIDTH-1:0]     lock_id_reg, lock_id_next;

    logic [2*NUM_REQ-1:0]    dbl_valid;
    logic [2*NUM_REQ-1:0]    shifted_valid;
    logic [NUM_REQ-1:0]      rot_valid;
    logic [ID_WIDTH-1:0]     grant_off;
    logic [ID_WIDTH:0]       grant_sum;
    logic [ID_WIDTH-1:0]     grant_id;
    logic                    grant_found;

    logic [ID_WIDTH-1:0]     sel_id;
    logic                    sel_open;
    logic                    sel_valid;
    logic                    accept;
    logic                    skid_in_ready;
    logic [PAYLOAD_W-1:0]    skid_in_data;
    logic [PAYLOAD_W-1:0]    skid_out_data;

    function automatic logic [ID_WIDTH-1:0] ptr_inc(input logic [ID_WIDTH-1:0] p);
        return (p == LAST_ID) ? '0 : p + 1'b1;
    endfunction

    // Rotate the request vector so bit 0 is the requester at rr_ptr, then
    // take the lowest set bit and rotate the offset back.
    assign dbl_valid     = {in_valid, in_valid};
    assign shifted_valid = dbl_valid >> rr_ptr_reg;
    assign rot_valid     = shifted_valid[NUM_REQ-1:0];

    always_comb begin
        grant_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_off = ID_WIDTH'(k);
            end
        end
    end

    assign grant_found = |in_valid;
    assign grant_sum   = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
    assign grant_id    = (grant_sum >= NUM_REQ_W) ? ID_WIDTH'(grant_sum - NUM_REQ_W)
                                                  : grant_sum[ID_WIDTH-1:0];

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        lock_id_next = lock_id_reg;
        sel_id       = grant_id;
        sel_open     = grant_found;
        sel_valid    = 1'b0;
        accept       = 1'b0;

        case (state_reg)
            ARB: begin
                sel_id    = grant_id;
                sel_open  = grant_found;
                sel_valid = grant_found;
                accept    = sel_valid & skid_in_ready;
                if (accept) begin
                    if (in_last[sel_id]) begin
                        rr_ptr_next = ptr_inc(grant_id);
                    end else begin
                        state_next   = LOCK;
                        lock_id_next = grant_id;
                    end
                end
            end
            LOCK: begin
                // Other requesters are shut out until the packet's last beat.
                sel_id    = lock_id_reg;
                sel_open  = 1'b1;
                sel_valid = in_valid[lock_id_reg];
                accept    = sel_valid & skid_in_ready;
                if (accept && in_last[sel_id]) begin
                    state_next  = ARB;
                    rr_ptr_next = ptr_inc(lock_id_reg);
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ARB;
            rr_ptr_reg  <= '0;
            lock_id_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            lock_id_reg <= lock_id_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign in_ready[gi] = sel_open & skid_in_ready & (sel_id == ID_WIDTH'(gi));
        end
    endgenerate

    assign skid_in_data = {sel_id, in_last[sel_id], in_data[sel_id]};

    skidbuf #(
        .WIDTH (PAYLOAD_W)
    ) u_skidbuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (sel_valid),
        .in_ready  (skid_in_ready),
        .in_data   (skid_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out_data)
    );

    assign {out_id, out_last, out_data} = skid_out_data;

endmodule
